// File: rtl/vga_line_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_line_prefetch: VGA timing plus one-line-ahead PSRAM prefetch into a    |
// | ping-pong line buffer. Optional VGA_SCALE2X_EN: half-resolution source.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_line_prefetch #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int MEM_WAIT = 2,
    parameter int ADDR_W   = 23
) (
    input  logic              clk_25Mhz,
    input  logic              reset,
    input  logic [ADDR_W-1:0] frame_base,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              ram_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n,
    input  logic [15:0]       mem_data_in,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [7:0]        pix_index,
    output logic              underrun
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW         = $clog2(H_TOTAL);
    localparam int VW         = $clog2(V_TOTAL);
    localparam int BANK_WORDS = H_ACTIVE / 2;
    localparam int BW         = $clog2(BANK_WORDS);
    localparam int WW         = $clog2(MEM_WAIT + 1);
`ifdef VGA_SCALE2X_EN
    localparam int FETCH_WORDS = H_ACTIVE / 4;
`else
    localparam int FETCH_WORDS = H_ACTIVE / 2;
`endif

    localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0]     LAST_WORD = BW'(FETCH_WORDS - 1);
    localparam logic [WW-1:0]     LAST_WAIT = WW'(MEM_WAIT - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(FETCH_WORDS);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hcount_q, hcount_d;
    logic [VW-1:0]     vcount_q, vcount_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [BW-1:0]     word_ptr_q, word_ptr_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              fetch_bank_q, fetch_bank_d;
    logic              underrun_q, underrun_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              video_on_q, video_on_d;
    logic [7:0]        pix_index_q, pix_index_d;

    logic [15:0]       bank0_mem [BANK_WORDS];
    logic [15:0]       bank1_mem [BANK_WORDS];

    logic              line_start, line_last, raw_active, trigger, target_bank, bank_we;
    logic              disp_bank, rd_hi;
    logic [BW-1:0]     rd_word;
    logic [15:0]       rd_data;
    logic [VW-1:0]     target_line;

    // Timing counters and the registered output stage
    always_comb begin
        hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
        end

        raw_active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        hsync_d    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
        vsync_d    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
        video_on_d = raw_active;

`ifdef VGA_SCALE2X_EN
        disp_bank = vcount_q[1];
        rd_word   = BW'(hcount_q >> 2);
        rd_hi     = hcount_q[1];
`else
        disp_bank = vcount_q[0];
        rd_word   = BW'(hcount_q >> 1);
        rd_hi     = hcount_q[0];
`endif
        rd_data     = disp_bank ? bank1_mem[rd_word] : bank0_mem[rd_word];
        pix_index_d = raw_active ? (rd_hi ? rd_data[15:8] : rd_data[7:0]) : 8'd0;
    end

    // The bank is chosen by the target line, so line 0 lands correctly even when V_TOTAL is odd
    always_comb begin
        line_start  = (hcount_q == '0);
        line_last   = (vcount_q == V_LAST);
        target_line = line_last ? '0 : vcount_q + VW'(1);
`ifdef VGA_SCALE2X_EN
        trigger     = line_start && (target_line < V_ACT) && !target_line[0];
        target_bank = target_line[1];
`else
        trigger     = line_start && (target_line < V_ACT);
        target_bank = target_line[0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        row_ptr_d    = row_ptr_q;
        word_ptr_d   = word_ptr_q;
        wait_cnt_d   = wait_cnt_q;
        fetch_bank_d = fetch_bank_q;
        underrun_d   = underrun_q;
        bank_we      = 1'b0;

        if (state_q == S_READ) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
            if (wait_cnt_q == LAST_WAIT) begin
                bank_we    = 1'b1;
                wait_cnt_d = '0;
                if (word_ptr_q == LAST_WORD) begin
                    state_d   = S_IDLE;
                    row_ptr_d = row_ptr_q + STRIDE;
                end else begin
                    word_ptr_d = word_ptr_q + BW'(1);
                    adr_d      = adr_q + ADDR_W'(1);
                end
            end
            // Still busy at a line start: the burst missed its deadline and is dropped
            if (line_start) begin
                underrun_d = 1'b1;
                state_d    = S_IDLE;
                row_ptr_d  = row_ptr_q;
            end
        end

        if (trigger) begin
            state_d      = S_READ;
            word_ptr_d   = '0;
            wait_cnt_d   = '0;
            fetch_bank_d = target_bank;
            if (line_last) begin
                row_ptr_d = frame_base;
                adr_d     = frame_base;
            end else begin
                adr_d     = row_ptr_q;
            end
        end
    end

    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hcount_q     <= '0;
            vcount_q     <= '0;
            adr_q        <= '0;
            row_ptr_q    <= '0;
            word_ptr_q   <= '0;
            wait_cnt_q   <= '0;
            fetch_bank_q <= 1'b0;
            underrun_q   <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            video_on_q   <= 1'b0;
            pix_index_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            adr_q        <= adr_d;
            row_ptr_q    <= row_ptr_d;
            word_ptr_q   <= word_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            fetch_bank_q <= fetch_bank_d;
            underrun_q   <= underrun_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            pix_index_q  <= pix_index_d;
        end
    end

    always_ff @(posedge clk_25Mhz) begin
        if (bank_we) begin
            if (fetch_bank_q) begin
                bank1_mem[word_ptr_q] <= mem_data_in;
            end else begin
                bank0_mem[word_ptr_q] <= mem_data_in;
            end
        end
    end

    // Chip enable comes straight from the state flop so reset releases the bus asynchronously
    assign ram_ce_n  = (state_q != S_READ);
    assign mem_oe_n  = (state_q != S_READ);
    assign mem_we_n  = 1'b1;
    assign ram_lb_n  = 1'b0;
    assign ram_ub_n  = 1'b0;
    assign mem_adr   = adr_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign pix_index = pix_index_q;
    assign underrun  = underrun_q;

endmodule
`default_nettype wire
